// File: rtl/lvds_video_pkg.sv
// Shared constants for the LVDS video path: word bit map, panel defaults,
// receiver lock states and a helper that unpacks one 21-bit word.
package lvds_video_pkg;

  localparam int WORD_W       = 21;
  localparam int DEF_H_ACTIVE = 1366;
  localparam int DEF_V_ACTIVE = 768;

  // Bit positions of each field inside the deserialized 21-bit word
  localparam int BIT_G0 = 0;
  localparam int BIT_R5 = 1;
  localparam int BIT_R4 = 2;
  localparam int BIT_R3 = 3;
  localparam int BIT_R2 = 4;
  localparam int BIT_R1 = 5;
  localparam int BIT_R0 = 6;
  localparam int BIT_B1 = 7;
  localparam int BIT_B0 = 8;
  localparam int BIT_G5 = 9;
  localparam int BIT_G4 = 10;
  localparam int BIT_G3 = 11;
  localparam int BIT_G2 = 12;
  localparam int BIT_G1 = 13;
  localparam int BIT_DE = 14;
  localparam int BIT_VS = 15;
  localparam int BIT_HS = 16;
  localparam int BIT_B5 = 17;
  localparam int BIT_B4 = 18;
  localparam int BIT_B3 = 19;
  localparam int BIT_B2 = 20;

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} rx_state_e;

  typedef struct packed {
    logic [5:0] red;
    logic [5:0] green;
    logic [5:0] blue;
    logic       hs;
    logic       vs;
    logic       de;
  } pixel_t;

  // Idle line: black, syncs inactive (high), no data enable
  localparam pixel_t PIX_IDLE = '{red: 6'd0, green: 6'd0, blue: 6'd0,
                                  hs: 1'b1, vs: 1'b1, de: 1'b0};

  function automatic pixel_t unpack_word(input logic [WORD_W-1:0] w);
    pixel_t p;
    p.red   = {w[BIT_R5], w[BIT_R4], w[BIT_R3], w[BIT_R2], w[BIT_R1], w[BIT_R0]};
    p.green = {w[BIT_G5], w[BIT_G4], w[BIT_G3], w[BIT_G2], w[BIT_G1], w[BIT_G0]};
    p.blue  = {w[BIT_B5], w[BIT_B4], w[BIT_B3], w[BIT_B2], w[BIT_B1], w[BIT_B0]};
    p.hs    = w[BIT_HS];
    p.vs    = w[BIT_VS];
    p.de    = w[BIT_DE];
    return p;
  endfunction

endpackage

// File: rtl/lvds_timing_meas.sv
// Sync edge detection, pixel coordinates, line/frame measurement with
// saturating counters, missing-VSync timeout and the per-frame ok/bad strobe.
module lvds_timing_meas
  import lvds_video_pkg::*;
#(
  parameter int EXP_H_ACTIVE  = DEF_H_ACTIVE,
  parameter int EXP_V_ACTIVE  = DEF_V_ACTIVE,
  parameter int CNT_W         = 12,
  parameter int TIMEOUT_LINES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic             hs_i,
  input  logic             vs_i,
  input  logic             de_i,
  output logic [CNT_W-1:0] pix_x_o,
  output logic [CNT_W-1:0] pix_y_o,
  output logic             line_start_o,
  output logic             frame_start_o,
  output logic [CNT_W-1:0] meas_h_active_o,
  output logic [CNT_W-1:0] meas_v_active_o,
  output logic [CNT_W-1:0] meas_h_total_o,
  output logic             frame_evt_o,
  output logic             frame_vs_o,
  output logic             frame_ok_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] EXP_H    = CNT_W'(EXP_H_ACTIVE);
  localparam logic [CNT_W-1:0] EXP_V    = CNT_W'(EXP_V_ACTIVE);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_LINES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic prev_hs_q, prev_vs_q, prev_de_q, prev_hs_d, prev_vs_d, prev_de_d;
  logic [CNT_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [CNT_W-1:0] h_act_q, h_act_d, h_tot_q, h_tot_d, v_cnt_q, v_cnt_d, tmo_q, tmo_d;
  logic [CNT_W-1:0] meas_ha_q, meas_ha_d, meas_va_q, meas_va_d, meas_ht_q, meas_ht_d;
  logic first_line_q, first_line_d, line_bad_q, line_bad_d;
  logic line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic de_rise, de_fall, hs_fall, vs_rise, tmo_hit, h_bad;

  // Edge strobes against the previous valid word, then next-state of all counters
  always_comb begin
    de_rise = valid_i &  de_i & ~prev_de_q;
    de_fall = valid_i & ~de_i &  prev_de_q;
    hs_fall = valid_i & ~hs_i &  prev_hs_q;
    vs_rise = valid_i &  vs_i & ~prev_vs_q;
    tmo_hit = hs_fall & ~vs_rise & (tmo_q == TMO_LAST);
    h_bad   = de_fall & (h_act_q != EXP_H);

    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
    prev_hs_d     = prev_hs_q;
    prev_vs_d     = prev_vs_q;
    prev_de_d     = prev_de_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    h_act_d       = h_act_q;
    h_tot_d       = h_tot_q;
    v_cnt_d       = v_cnt_q;
    tmo_d         = tmo_q;
    meas_ha_d     = meas_ha_q;
    meas_va_d     = meas_va_q;
    meas_ht_d     = meas_ht_q;
    first_line_d  = first_line_q;
    line_bad_d    = line_bad_q;
    line_start_d  = de_rise;
    frame_start_d = vs_rise;

    if (valid_i) begin
      prev_hs_d = hs_i;
      prev_vs_d = vs_i;
      prev_de_d = de_i;
      h_tot_d   = sat_inc(h_tot_q);
    end

    if (de_rise) begin
      pix_x_d      = '0;
      h_act_d      = CNT_W'(1);
      pix_y_d      = first_line_q ? '0 : sat_inc(pix_y_q);
      first_line_d = 1'b0;
      v_cnt_d      = sat_inc(v_cnt_q);
    end else if (valid_i && de_i) begin
      pix_x_d = sat_inc(pix_x_q);
      h_act_d = sat_inc(h_act_q);
    end

    if (de_fall) begin
      meas_ha_d = h_act_q;
      if (h_bad) line_bad_d = 1'b1;
    end

    if (hs_fall) begin
      meas_ht_d = h_tot_q;
      h_tot_d   = CNT_W'(1);
      tmo_d     = tmo_q + 1'b1;
    end

    // A VSync rise closes the frame; a timeout closes it without a measurement
    if (vs_rise) begin
      meas_va_d    = v_cnt_q;
      v_cnt_d      = de_rise ? CNT_W'(1) : '0;
      line_bad_d   = 1'b0;
      tmo_d        = '0;
      first_line_d = ~de_rise;
    end else if (tmo_hit) begin
      v_cnt_d    = de_rise ? CNT_W'(1) : '0;
      line_bad_d = 1'b0;
      tmo_d      = '0;
    end
  end

  // Register all timing state; reset to idle sync history and zero counts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_hs_q     <= 1'b1;
      prev_vs_q     <= 1'b1;
      prev_de_q     <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      h_act_q       <= '0;
      h_tot_q       <= '0;
      v_cnt_q       <= '0;
      tmo_q         <= '0;
      meas_ha_q     <= '0;
      meas_va_q     <= '0;
      meas_ht_q     <= '0;
      // Treat reset like a frame boundary so the first DE line is row 0
      first_line_q  <= 1'b1;
      line_bad_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      // NOTE: state is updated with <= so every register samples pre-edge values.
      prev_hs_q     <= prev_hs_d;
      prev_vs_q     <= prev_vs_d;
      prev_de_q     <= prev_de_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      h_act_q       <= h_act_d;
      h_tot_q       <= h_tot_d;
      v_cnt_q       <= v_cnt_d;
      tmo_q         <= tmo_d;
      meas_ha_q     <= meas_ha_d;
      meas_va_q     <= meas_va_d;
      meas_ht_q     <= meas_ht_d;
      first_line_q  <= first_line_d;
      line_bad_q    <= line_bad_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_x_o         = pix_x_q;
  assign pix_y_o         = pix_y_q;
  assign line_start_o    = line_start_q;
  assign frame_start_o   = frame_start_q;
  assign meas_h_active_o = meas_ha_q;
  assign meas_v_active_o = meas_va_q;
  assign meas_h_total_o  = meas_ht_q;
  assign frame_evt_o     = vs_rise | tmo_hit;
  assign frame_vs_o      = vs_rise;
  assign frame_ok_o      = vs_rise & (v_cnt_q == EXP_V) & ~(line_bad_q | h_bad);

endmodule

// File: rtl/lvds_video_rx_decoder.sv
// Receive-side LVDS pixel decoder: unpacks the deserialized word to RGB666 and
// syncs, and tracks format lock with a SEARCH/CHECK/LOCKED state machine.
module lvds_video_rx_decoder
  import lvds_video_pkg::*;
#(
  parameter int EXP_H_ACTIVE  = DEF_H_ACTIVE,
  parameter int EXP_V_ACTIVE  = DEF_V_ACTIVE,
  parameter int CNT_W         = 12,
  parameter int LOCK_FRAMES   = 2,
  parameter int LOSS_FRAMES   = 2,
  parameter int TIMEOUT_LINES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_word,
  input  logic              err_clr,
  output logic              pix_valid,
  output logic [5:0]        red,
  output logic [5:0]        green,
  output logic [5:0]        blue,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [CNT_W-1:0]  pix_x,
  output logic [CNT_W-1:0]  pix_y,
  output logic              line_start,
  output logic              frame_start,
  output logic [CNT_W-1:0]  meas_h_active,
  output logic [CNT_W-1:0]  meas_v_active,
  output logic [CNT_W-1:0]  meas_h_total,
  output logic              locked,
  output logic              fmt_err
);

  localparam logic [CNT_W-1:0] LOCK_N = CNT_W'(LOCK_FRAMES);
  localparam logic [CNT_W-1:0] LOSS_N = CNT_W'(LOSS_FRAMES);

  pixel_t           pix_w, pix_q;
  logic             pix_valid_q;
  rx_state_e        state_q;
  logic [CNT_W-1:0] good_q, bad_q;
  logic             locked_q, fmt_err_q;
  logic             frame_evt, frame_vs, frame_ok, set_err;

  // Field extraction from the incoming word
  always_comb pix_w = unpack_word(in_word);

  lvds_timing_meas #(
    .EXP_H_ACTIVE (EXP_H_ACTIVE),
    .EXP_V_ACTIVE (EXP_V_ACTIVE),
    .CNT_W        (CNT_W),
    .TIMEOUT_LINES(TIMEOUT_LINES)
  ) u_meas (
    .clk            (clk),
    .rst            (rst),
    .valid_i        (in_valid),
    .hs_i           (pix_w.hs),
    .vs_i           (pix_w.vs),
    .de_i           (pix_w.de),
    .pix_x_o        (pix_x),
    .pix_y_o        (pix_y),
    .line_start_o   (line_start),
    .frame_start_o  (frame_start),
    .meas_h_active_o(meas_h_active),
    .meas_v_active_o(meas_v_active),
    .meas_h_total_o (meas_h_total),
    .frame_evt_o    (frame_evt),
    .frame_vs_o     (frame_vs),
    .frame_ok_o     (frame_ok)
  );

  // Pixel output register: updates only on accepted words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_valid_q <= 1'b0;
      pix_q       <= PIX_IDLE;
    end else begin
      pix_valid_q <= in_valid;
      if (in_valid) pix_q <= pix_w;
    end
  end

  // A bad frame while locked is a format error
  assign set_err = frame_evt & ~frame_ok & (state_q == LOCKED);

  // Lock state machine with registered locked/fmt_err; setting beats clearing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SEARCH;
      good_q    <= '0;
      bad_q     <= '0;
      locked_q  <= 1'b0;
      fmt_err_q <= 1'b0;
    end else begin
      if (set_err)      fmt_err_q <= 1'b1;
      else if (err_clr) fmt_err_q <= 1'b0;

      if (frame_evt) begin
        case (state_q)
          SEARCH: begin
            // The frame in progress at entry is partial, so it is not judged
            if (frame_vs) begin
              state_q <= CHECK;
              good_q  <= '0;
            end
          end
          CHECK: begin
            if (!frame_ok) begin
              good_q <= '0;
            end else if (good_q + 1'b1 >= LOCK_N) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              bad_q    <= '0;
            end else begin
              good_q <= good_q + 1'b1;
            end
          end
          LOCKED: begin
            if (frame_ok) begin
              bad_q <= '0;
            end else begin
              bad_q <= bad_q + 1'b1;
              if (bad_q + 1'b1 >= LOSS_N) begin
                state_q  <= SEARCH;
                locked_q <= 1'b0;
              end
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  assign pix_valid = pix_valid_q;
  assign red       = pix_q.red;
  assign green     = pix_q.green;
  assign blue      = pix_q.blue;
  assign hsync     = pix_q.hs;
  assign vsync     = pix_q.vs;
  assign de        = pix_q.de;
  assign locked    = locked_q;
  assign fmt_err   = fmt_err_q;

endmodule

// File: tb/tb_lvds_video_rx_decoder.sv
// Directed bench for lvds_video_rx_decoder. The panel is scaled down to
// 16x8 active (24 words/line, 12 lines/frame) so whole frames run quickly;
// counter width and the 1024-line timeout keep their full values.
module tb_lvds_video_rx_decoder;
  import lvds_video_pkg::*;

  localparam int H_ACT   = 16;
  localparam int V_ACT   = 8;
  localparam int H_BLANK = 8;
  localparam int V_BLANK = 4;
  localparam int CNT_W   = 12;
  localparam int TMO     = 1024;

  logic              clk = 1'b0;
  logic              rst, in_valid, err_clr;
  logic [WORD_W-1:0] in_word;
  logic              pix_valid, hsync, vsync, de, line_start, frame_start, locked, fmt_err;
  logic [5:0]        red, green, blue;
  logic [CNT_W-1:0]  pix_x, pix_y, meas_h_active, meas_v_active, meas_h_total;

  lvds_video_rx_decoder #(
    .EXP_H_ACTIVE(H_ACT), .EXP_V_ACTIVE(V_ACT), .CNT_W(CNT_W),
    .LOCK_FRAMES(2), .LOSS_FRAMES(2), .TIMEOUT_LINES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .err_clr(err_clr),
    .pix_valid(pix_valid), .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .de(de), .pix_x(pix_x), .pix_y(pix_y),
    .line_start(line_start), .frame_start(frame_start),
    .meas_h_active(meas_h_active), .meas_v_active(meas_v_active),
    .meas_h_total(meas_h_total), .locked(locked), .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor and stream-model state
  int   ls_cnt, fs_cnt, max_x, max_y;
  bit   gap_pulse;
  bit   m_hs, m_vs;
  int   m_hs_falls;
  bit   arm_tmo, force_clr;
  logic last_fmt;

  task automatic clear_monitor();
    ls_cnt = 0; fs_cnt = 0; max_x = -1; max_y = -1; gap_pulse = 1'b0;
  endtask

  // One clock: drive a word (random colour), sample outputs 1 time unit after the edge
  task automatic send_word(input bit v, input bit hs, input bit vs, input bit d);
    logic [WORD_W-1:0] w;
    bit vs_r, hs_f, will_tmo;
    w = WORD_W'($urandom);
    if (v) begin
      w[BIT_HS] = hs;
      w[BIT_VS] = vs;
      w[BIT_DE] = d;
    end
    vs_r     = v && vs && !m_vs;
    hs_f     = v && !hs && m_hs;
    will_tmo = hs_f && !vs_r && (m_hs_falls == TMO - 1);
    last_fmt = fmt_err;
    in_valid = v;
    in_word  = w;
    err_clr  = force_clr || (will_tmo && arm_tmo);
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    if (v) begin
      m_hs = hs;
      m_vs = vs;
      if (vs_r)      m_hs_falls = 0;
      else if (hs_f) m_hs_falls = will_tmo ? 0 : m_hs_falls + 1;
    end
    if (!v && (pix_valid || line_start || frame_start)) gap_pulse = 1'b1;
    if (line_start)  ls_cnt++;
    if (frame_start) fs_cnt++;
    if (pix_valid && de) begin
      if (int'(pix_x) > max_x) max_x = int'(pix_x);
      if (int'(pix_y) > max_y) max_y = int'(pix_y);
    end
    if (will_tmo && arm_tmo) begin
      check("tmo_fmt_err_before", 32'(last_fmt), 32'd0);
      check("tmo_set_beats_clr", 32'(fmt_err), 32'd1);
      check("tmo_no_frame_start", 32'(frame_start), 32'd0);
      arm_tmo = 1'b0;
    end
  endtask

  // One line: de_len DE words, blanking, HSync low for 3 words early in blanking
  task automatic send_line(input bit vs, input int de_len, input bit gap);
    int len, hs0;
    len = ((de_len > H_ACT) ? de_len : H_ACT) + H_BLANK;
    hs0 = len - H_BLANK + 2;
    for (int w = 0; w < len; w++) begin
      if (gap) send_word(1'b0, 1'b0, 1'b0, 1'b0);
      send_word(1'b1, !(w >= hs0 && w < hs0 + 3), vs, w < de_len);
    end
  endtask

  // One frame: V_ACT DE lines, VSync low for two blank lines, VS rises on the last line
  task automatic send_frame(input int short_line, input bit gap);
    for (int l = 0; l < V_ACT + V_BLANK; l++) begin
      send_line(!(l == V_ACT + 1 || l == V_ACT + 2),
                (l < V_ACT) ? ((l == short_line) ? H_ACT - 1 : H_ACT) : 0, gap);
    end
  endtask

  task automatic reset_model();
    m_hs = 1'b1; m_vs = 1'b1; m_hs_falls = 0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; err_clr = 1'b0; in_word = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    reset_model();
    clear_monitor();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_rgb"}, {14'd0, red, green, blue}, 32'd0);
    check({tag, "_syncs"}, {29'd0, hsync, vsync, de}, 32'b110);
    check({tag, "_pix_xy"}, {8'd0, pix_x, pix_y}, 32'd0);
    check({tag, "_meas_ha"}, 32'(meas_h_active), 32'd0);
    check({tag, "_meas_va"}, 32'(meas_v_active), 32'd0);
    check({tag, "_meas_ht"}, 32'(meas_h_total), 32'd0);
    check({tag, "_pulses"}, {30'd0, line_start, frame_start}, 32'd0);
    check({tag, "_lock_err"}, {30'd0, locked, fmt_err}, 32'd0);
    check({tag, "_state"}, 32'(dut.state_q), 32'(SEARCH));
  endtask

  typedef struct {
    logic              valid;
    logic [WORD_W-1:0] word;
    logic              pv;
    logic [5:0]        r, g, b;
    logic              hs, vs, d, ls, fs;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [WORD_W-1:0] w, input logic pv,
                              input logic [5:0] r, input logic [5:0] g, input logic [5:0] b,
                              input logic hs, input logic vs, input logic d,
                              input logic ls, input logic fs);
    vec_t t;
    t.valid = v; t.word = w; t.pv = pv; t.r = r; t.g = g; t.b = b;
    t.hs = hs; t.vs = vs; t.d = d; t.ls = ls; t.fs = fs;
    return t;
  endfunction

  vec_t vecs[17];

  initial begin
    // Unpack vectors: each row's outputs appear one clock after the word
    vecs[0]  = mk(1, 21'h1FFFFF, 1, 63, 63, 63, 1, 1, 1, 1, 0);
    vecs[1]  = mk(0, 21'h000000, 0, 63, 63, 63, 1, 1, 1, 0, 0);
    vecs[2]  = mk(1, 21'h000000, 1,  0,  0,  0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 21'h00007E, 1, 63,  0,  0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 21'h000002, 1, 32,  0,  0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(1, 21'h000040, 1,  1,  0,  0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(1, 21'h000001, 1,  0,  1,  0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(1, 21'h000200, 1,  0, 32,  0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 21'h000100, 1,  0,  0,  1, 0, 0, 0, 0, 0);
    vecs[9]  = mk(1, 21'h000080, 1,  0,  0,  2, 0, 0, 0, 0, 0);
    vecs[10] = mk(1, 21'h020000, 1,  0,  0, 32, 0, 0, 0, 0, 0);
    vecs[11] = mk(1, 21'h100000, 1,  0,  0,  4, 0, 0, 0, 0, 0);
    vecs[12] = mk(1, 21'h010000, 1,  0,  0,  0, 1, 0, 0, 0, 0);
    vecs[13] = mk(1, 21'h008000, 1,  0,  0,  0, 0, 1, 0, 0, 1);
    vecs[14] = mk(1, 21'h004000, 1,  0,  0,  0, 0, 0, 1, 1, 0);
    vecs[15] = mk(1, 21'h003E00, 1,  0, 62,  0, 0, 0, 0, 0, 0);
    vecs[16] = mk(1, 21'h1E0000, 1,  0,  0, 60, 0, 0, 0, 0, 0);

    arm_tmo = 1'b0; force_clr = 1'b0;
    rst = 1'b1; in_valid = 1'b0; err_clr = 1'b0; in_word = '0;
    reset_model();
    clear_monitor();
    @(posedge clk);
    #1;
    check_reset("rst0");
    rst = 1'b0;

    // Table-driven unpack and edge pulses
    for (int i = 0; i < 17; i++) begin
      in_valid = vecs[i].valid;
      in_word  = vecs[i].word;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i),
            {8'd0, pix_valid, red, green, blue, hsync, vsync, de, line_start, frame_start},
            {8'd0, vecs[i].pv, vecs[i].r, vecs[i].g, vecs[i].b,
             vecs[i].hs, vecs[i].vs, vecs[i].d, vecs[i].ls, vecs[i].fs});
    end

    // Three clean frames: lock after the third VSync rise
    do_reset();
    for (int f = 0; f < 3; f++) begin
      send_frame(-1, 1'b0);
      if (f == 0) begin
        check("lock_state_after_f1", 32'(dut.state_q), 32'(CHECK));
        max_x = -1; max_y = -1;
      end
      if (f == 1) check("lock_locked_after_f2", 32'(locked), 32'd0);
    end
    check("lock_locked_after_f3", 32'(locked), 32'd1);
    check("lock_meas_h_active", 32'(meas_h_active), H_ACT);
    check("lock_meas_v_active", 32'(meas_v_active), V_ACT);
    check("lock_meas_h_total", 32'(meas_h_total), H_ACT + H_BLANK);
    check("lock_max_x", max_x, H_ACT - 1);
    check("lock_max_y", max_y, V_ACT - 1);
    check("lock_line_starts", ls_cnt, 3 * V_ACT);
    check("lock_frame_starts", fs_cnt, 3);

    // Two frames with one short line: error on the first, lock lost on the second
    send_frame(3, 1'b0);
    check("loss_fmt_err_f1", 32'(fmt_err), 32'd1);
    check("loss_locked_f1", 32'(locked), 32'd1);
    send_frame(3, 1'b0);
    check("loss_locked_f2", 32'(locked), 32'd0);
    check("loss_state_f2", 32'(dut.state_q), 32'(SEARCH));

    // Relock with every other cycle idle: identical measurements, no pulses in gaps
    clear_monitor();
    for (int f = 0; f < 3; f++) begin
      send_frame(-1, 1'b1);
      if (f == 0) begin
        check("gap_state_after_f1", 32'(dut.state_q), 32'(CHECK));
        max_x = -1; max_y = -1;
      end
      if (f == 1) check("gap_locked_after_f2", 32'(locked), 32'd0);
    end
    check("gap_locked_after_f3", 32'(locked), 32'd1);
    check("gap_meas_h_active", 32'(meas_h_active), H_ACT);
    check("gap_meas_v_active", 32'(meas_v_active), V_ACT);
    check("gap_meas_h_total", 32'(meas_h_total), H_ACT + H_BLANK);
    check("gap_max_x", max_x, H_ACT - 1);
    check("gap_max_y", max_y, V_ACT - 1);
    check("gap_line_starts", ls_cnt, 3 * V_ACT);
    check("gap_frame_starts", fs_cnt, 3);
    check("gap_pulse_in_idle", 32'(gap_pulse), 32'd0);

    // Clear the sticky error
    force_clr = 1'b1;
    send_word(1'b1, 1'b1, 1'b1, 1'b0);
    force_clr = 1'b0;
    check("clr_fmt_err", 32'(fmt_err), 32'd0);

    // VSync stuck high for 1100 lines: one timeout at the 1024th HSync fall,
    // with err_clr in that same cycle
    clear_monitor();
    arm_tmo = 1'b1;
    for (int l = 0; l < 1100; l++) send_line(1'b1, H_ACT, 1'b0);
    check("tmo_hook_reached", 32'(arm_tmo), 32'd0);
    check("tmo_frame_starts", fs_cnt, 0);
    check("tmo_fmt_err_after", 32'(fmt_err), 32'd1);
    check("tmo_still_locked", 32'(locked), 32'd1);

    // Over-long line: measurements saturate rather than wrap
    send_line(1'b1, 4200, 1'b0);
    check("sat_meas_h_active", 32'(meas_h_active), 32'd4095);
    check("sat_pix_x", 32'(pix_x), 32'd4095);
    check("sat_meas_h_total", 32'(meas_h_total), 32'd4095);

    // Asynchronous reset mid-line while locked, then relock from scratch
    for (int w = 0; w < 12; w++) send_word(1'b1, 1'b1, 1'b1, 1'b1);
    check("arst_pre_locked", 32'(locked), 32'd1);
    check("arst_pre_pix_x", 32'(pix_x), 32'd11);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset("arst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    reset_model();
    clear_monitor();
    for (int f = 0; f < 3; f++) begin
      send_frame(-1, 1'b0);
      if (f < 2) check($sformatf("relock_locked_f%0d", f + 1), 32'(locked), 32'd0);
    end
    check("relock_locked_f3", 32'(locked), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

endmodule
